// File: rtl/cla_sub_pipe_42bit.sv
// cla_sub_pipe_42bit
//   Two-stage pipelined borrow-lookahead subtractor.
//   o_result = {borrow, i_min - i_sub}; borrow=1 iff i_min < i_sub (unsigned).
//   o_ovf flags signed (two's complement) overflow of i_min - i_sub.
//   Stage 1 subtracts the low SPLIT bits and carries the upper operand bits.
//   Stage 2 subtracts the upper bits with the stage-1 borrow and drives the outputs.
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     operand handshake (o_ready has no i_valid dependency)
//   i_min, i_sub          WIDTH-bit unsigned minuend / subtrahend
//   o_valid / i_ready     result handshake
//   o_result              WIDTH+1 bits {borrow, difference}
//   o_ovf                 signed overflow of the subtraction

// Borrow-lookahead subtractor block: G=~a&b generates a borrow, P=~a|b
// propagates an incoming one.
module cla_sub_blk #(
  parameter int W = 21
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);
  logic [W-1:0] g, p;
  logic [W:0]   bc;

  assign g = ~a & b;
  assign p = ~a | b;

  always_comb begin
    bc    = '0;
    bc[0] = bin;
    for (int i = 0; i < W; i++) begin
      bc[i+1] = g[i] | (p[i] & bc[i]);
    end
  end

  assign diff = a ^ b ^ bc[W-1:0];
  assign bout = bc[W];
endmodule

module cla_sub_pipe_42bit #(
  parameter int WIDTH = 42,
  parameter int SPLIT = 21
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);
  localparam int HI = WIDTH - SPLIT;

  // stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_lo_diff_q, s1_lo_diff_d;
  logic             s1_lo_bout_q, s1_lo_bout_d;
  logic [HI-1:0]    s1_hi_min_q, s1_hi_min_d;
  logic [HI-1:0]    s1_hi_sub_q, s1_hi_sub_d;

  // stage 2 (output) state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s2_result_q, s2_result_d;
  logic             s2_ovf_q, s2_ovf_d;

  logic             s1_adv, s2_adv;
  logic [SPLIT-1:0] lo_diff;
  logic             lo_bout;
  logic [HI-1:0]    hi_diff;
  logic             hi_bout;

  cla_sub_blk #(.W(SPLIT)) u_lo (
    .a    (i_min[SPLIT-1:0]),
    .b    (i_sub[SPLIT-1:0]),
    .bin  (1'b0),
    .diff (lo_diff),
    .bout (lo_bout)
  );

  cla_sub_blk #(.W(HI)) u_hi (
    .a    (s1_hi_min_q),
    .b    (s1_hi_sub_q),
    .bin  (s1_lo_bout_q),
    .diff (hi_diff),
    .bout (hi_bout)
  );

  // A stage may advance if it is empty or the stage after it is moving.
  assign s2_adv  = ~s2_valid_q | i_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign o_ready = s1_adv;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_lo_diff_d = s1_lo_diff_q;
    s1_lo_bout_d = s1_lo_bout_q;
    s1_hi_min_d  = s1_hi_min_q;
    s1_hi_sub_d  = s1_hi_sub_q;
    s2_valid_d   = s2_valid_q;
    s2_result_d  = s2_result_q;
    s2_ovf_d     = s2_ovf_q;

    // Data loads whenever the stage advances; contents are don't-care
    // while the matching valid is low.
    if (s1_adv) begin
      s1_valid_d   = i_valid;
      s1_lo_diff_d = lo_diff;
      s1_lo_bout_d = lo_bout;
      s1_hi_min_d  = i_min[WIDTH-1:SPLIT];
      s1_hi_sub_d  = i_sub[WIDTH-1:SPLIT];
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = {hi_bout, hi_diff, s1_lo_diff_q};
        // Overflow only when operand signs differ and the result sign
        // disagrees with the minuend.
        s2_ovf_d    = (s1_hi_min_q[HI-1] != s1_hi_sub_q[HI-1]) &&
                      (hi_diff[HI-1] != s1_hi_min_q[HI-1]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q   <= 1'b0;
      s1_lo_diff_q <= '0;
      s1_lo_bout_q <= 1'b0;
      s1_hi_min_q  <= '0;
      s1_hi_sub_q  <= '0;
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_ovf_q     <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_lo_diff_q <= s1_lo_diff_d;
      s1_lo_bout_q <= s1_lo_bout_d;
      s1_hi_min_q  <= s1_hi_min_d;
      s1_hi_sub_q  <= s1_hi_sub_d;
      s2_valid_q   <= s2_valid_d;
      s2_result_q  <= s2_result_d;
      s2_ovf_q     <= s2_ovf_d;
    end
  end

  assign o_valid  = s2_valid_q;
  assign o_result = s2_result_q;
  assign o_ovf    = s2_ovf_q;
endmodule

// File: tb/tb_cla_sub_pipe_42bit.sv
module tb_cla_sub_pipe_42bit;
  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_ready;
  logic        o_ready, o_valid, o_ovf;
  logic [41:0] i_min, i_sub;
  logic [42:0] o_result;

  cla_sub_pipe_42bit dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_min    (i_min),
    .i_sub    (i_sub),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  int          n_pass = 0, n_total = 0;
  int          npush = 0, npop = 0;
  logic [43:0] sb[$];
  logic        rdy_s, vld_s;
  logic [43:0] res_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {ovf, borrow, diff}. Overflow from a widened signed difference.
  function automatic logic [43:0] model(input logic [41:0] a, input logic [41:0] b);
    logic [42:0]        u;
    logic signed [42:0] s;
    u = {1'b0, a} - {1'b0, b};
    s = $signed({a[41], a}) - $signed({b[41], b});
    return {(s[42] != s[41]), u};
  endfunction

  function automatic logic [41:0] rnd42();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       return 42'd0;
      1:       return {42{1'b1}};
      2:       return 42'h200_0000_0000;
      3:       return 42'h1F_FFFF;
      default: return r[41:0];
    endcase
  endfunction

  // Inputs are driven at a negedge; sample #1 later, then run to next negedge.
  task automatic tick();
    logic [43:0] e;
    #1;
    rdy_s = o_ready;
    vld_s = o_valid;
    res_s = {o_ovf, o_result};
    if (!i_rst) begin
      if (o_valid && i_ready) begin
        chk("out_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_result", 64'(res_s), 64'(e));
        end
        npop++;
      end
      if (i_valid && o_ready) begin
        sb.push_back(model(i_min, i_sub));
        npush++;
      end
    end
    @(negedge clk);
    if (i_rst) sb.delete();
  endtask

  task automatic run_one(input string tag, input logic [41:0] a, input logic [41:0] b,
                         input logic [43:0] exp);
    i_ready = 1'b1;
    i_min = a; i_sub = b; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    #1;
    chk({tag, "_vld"}, 64'(o_valid), 64'd1);
    chk(tag, 64'({o_ovf, o_result}), 64'(exp));
    tick();
  endtask

  initial begin
    int p0, c;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_min = '0; i_sub = '0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("rst_vld", 64'(o_valid), 64'd0);
    chk("rst_res", 64'(o_result), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    chk("rst_rdy", 64'(o_ready), 64'd1);
    @(negedge clk);

    // Directed values
    run_one("sub_100_58", 42'd100, 42'd58, {1'b0, 1'b0, 42'd42});
    run_one("sub_0_1", 42'd0, 42'd1, {1'b0, 1'b1, 42'h3FF_FFFF_FFFF});
    run_one("split_borrow", 42'h1F_FFFF, 42'h20_0000, {1'b0, 1'b1, 42'h3FF_FFFF_FFFF});
    run_one("neg_ovf", 42'h200_0000_0000, 42'd1, {1'b1, 1'b0, 42'h1FF_FFFF_FFFF});
    run_one("equal", 42'h155_AAAA_5555, 42'h155_AAAA_5555, 44'd0);

    // Stream 8 back-to-back: 8 pops in the 8 ticks after the 2-cycle latency
    i_ready = 1'b1;
    p0 = npop;
    for (int k = 0; k < 8; k++) begin
      i_min = rnd42(); i_sub = rnd42(); i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    tick();
    tick();
    chk("stream_cnt", 64'(npop - p0), 64'd8);

    // Stall: o_ready drops after 2 accepts; held output stable
    i_ready = 1'b0;
    i_min = rnd42(); i_sub = rnd42(); i_valid = 1'b1; tick();
    chk("stall_rdy1", 64'(rdy_s), 64'd1);
    i_min = rnd42(); i_sub = rnd42(); tick();
    chk("stall_rdy2", 64'(rdy_s), 64'd1);
    i_min = rnd42(); i_sub = rnd42(); tick();
    chk("stall_rdy3", 64'(rdy_s), 64'd0);
    chk("stall_vld", 64'(vld_s), 64'd1);
    begin
      logic [43:0] held;
      held = res_s;
      i_min = rnd42(); i_sub = rnd42(); tick();
      chk("stall_rdy4", 64'(rdy_s), 64'd0);
      chk("stall_hold", 64'(res_s), 64'(held));
    end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("stall_drain", 64'(sb.size()), 64'd0);
    chk("stall_nodrop", 64'(npop), 64'(npush));

    // Reset with the pipeline full
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_min = rnd42(); i_sub = rnd42(); i_valid = 1'b1; tick();
    end
    chk("full_rdy", 64'(rdy_s), 64'd0);
    i_rst = 1'b1; i_ready = 1'b1;
    tick();
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    chk("rst2_vld", 64'(o_valid), 64'd0);
    chk("rst2_res", 64'(o_result), 64'd0);
    chk("rst2_ovf", 64'(o_ovf), 64'd0);
    chk("rst2_rdy", 64'(o_ready), 64'd1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst2_nostale", 64'(vld_s), 64'd0);
    end
    npush = 0; npop = 0;

    // Random traffic
    p0 = npush;
    c = 0;
    while (c < 60000 && (npush - p0) < 10000) begin
      i_min = rnd42(); i_sub = rnd42();
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
      c++;
    end
    chk("rand_accepts", 64'(npush - p0), 64'd10000);
    i_valid = 1'b0; i_ready = 1'b1;
    c = 0;
    while (c < 50 && sb.size() > 0) begin
      tick();
      c++;
    end
    chk("rand_drain", 64'(sb.size()), 64'd0);
    chk("rand_nodrop", 64'(npop), 64'(npush));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
